ir_tx_nec_fifo: RTL and testbench

- Avalon-MM slave IR transmitter, the send-side counterpart of the team's IR receive path.
- Queues 32-bit NEC codes written by the HPS/Nios into a small FIFO.
- Serialises each code as an NEC frame (leader, 32 bits LSB first, stop mark) on a 38 kHz carrier driving the IR LED.
- Raises an interrupt when the queue has drained.

---
 rtl/ir_tx_nec_fifo.sv | 194 +++++++++++++++++++
 tb/tb_ir_tx_nec_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_tx_nec_fifo.sv
// NEC IR transmitter with an Avalon-MM FIFO front end and drain interrupt.
// Define IR_TX_CARRIER_EN to modulate marks with the carrier; otherwise ir is the baseband envelope.
module ir_tx_nec_fifo #(
  parameter int UNIT_CYCLES    = 28125,
  parameter int CARRIER_PERIOD = 1316,
  parameter int CARRIER_HIGH   = 439,
  parameter int GAP_UNITS      = 72,
  parameter int FIFO_AW        = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        irq,
  input  logic        s_address,
  input  logic        s_cs_n,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        ir
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int UC_W  = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int UN_W  = $clog2(((GAP_UNITS > 16) ? GAP_UNITS : 16) + 1);

  if (CARRIER_HIGH >= CARRIER_PERIOD) begin : g_param_chk
    $error("CARRIER_HIGH must be less than CARRIER_PERIOD");
  end

  typedef enum logic [2:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP
  } state_t;

  state_t               state, state_nx;
  logic [31:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
  logic [FIFO_AW:0]     used;
  logic [31:0]          shreg;
  logic [4:0]           bit_cnt;
  logic [UC_W-1:0]      cyc_cnt;
  logic [UN_W-1:0]      unit_cnt, last_unit;
  logic                 irq_pend, irq_en, ovf;
  logic                 acc, wr_data, wr_cs, rd_en, fifo_clr;
  logic                 empty, full, push, pop, drop;
  logic                 unit_end, state_done, irq_set, ir_d;
  logic [31:0]          cs_word;

  function automatic logic [UN_W-1:0] state_units(input state_t s, input logic b);
    logic [UN_W-1:0] u;
    case (s)
      LEAD_MARK:  u = UN_W'(16);
      LEAD_SPACE: u = UN_W'(8);
      BIT_SPACE:  u = b ? UN_W'(3) : UN_W'(1);
      GAP:        u = UN_W'(GAP_UNITS);
      default:    u = UN_W'(1);
    endcase
    return u;
  endfunction

  function automatic logic is_mark(input state_t s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

  assign acc      = ~s_cs_n;
  assign wr_data  = acc & s_write & ~s_address;
  assign wr_cs    = acc & s_write & s_address;
  assign rd_en    = acc & s_read;
  assign fifo_clr = wr_cs & s_writedata[0];
  assign empty    = (used == '0);
  assign full     = (used == (FIFO_AW+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push     = wr_data & (~full | pop) & ~fifo_clr;
  assign drop     = wr_data & full & ~pop & ~fifo_clr;

  assign unit_end   = (cyc_cnt == UC_W'(UNIT_CYCLES - 1));
  assign last_unit  = state_units(state, shreg[0]) - UN_W'(1);
  assign state_done = unit_end && (unit_cnt == last_unit);
  assign irq        = irq_pend & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (!empty)    state_nx = LEAD_MARK;
      LEAD_MARK:  if (state_done) state_nx = LEAD_SPACE;
      LEAD_SPACE: if (state_done) state_nx = BIT_MARK;
      BIT_MARK:   if (state_done) state_nx = BIT_SPACE;
      BIT_SPACE:  if (state_done) state_nx = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (state_done) state_nx = GAP;
      GAP:        if (state_done) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

`ifdef IR_TX_CARRIER_EN
  localparam int CP_W = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
  logic [CP_W-1:0] carrier, carrier_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) carrier <= '0;
    else          carrier <= carrier_nx;
  end
`endif

  // ir is registered, so it is driven from the next state to hit the first mark cycle.
  always_comb begin
    pop     = (state == IDLE) && !empty;
    irq_set = (state == STOP_MARK) && state_done && empty;
`ifdef IR_TX_CARRIER_EN
    if (state_nx != state)                          carrier_nx = '0;
    else if (carrier == CP_W'(CARRIER_PERIOD - 1))  carrier_nx = '0;
    else                                            carrier_nx = carrier + 1'b1;
    ir_d = is_mark(state_nx) && (carrier_nx < CP_W'(CARRIER_HIGH));
`else
    ir_d = is_mark(state_nx);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir       <= 1'b0;
      cyc_cnt  <= '0;
      unit_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      ir <= ir_d;
      if (state_nx != state || state == IDLE) begin
        cyc_cnt  <= '0;
        unit_cnt <= '0;
      end else if (unit_end) begin
        cyc_cnt  <= '0;
        unit_cnt <= unit_cnt + 1'b1;
      end else begin
        cyc_cnt  <= cyc_cnt + 1'b1;
      end
      if (pop)                                  bit_cnt <= '0;
      else if (state == BIT_SPACE && state_done) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_writedata;
    if (pop)                                    shreg <= mem[rd_ptr];
    else if (state == BIT_SPACE && state_done)  shreg <= {1'b0, shreg[31:1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (fifo_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      used <= used + 1'b1;
      else if (!push && pop) used <= used - 1'b1;
    end
  end

  always_comb begin
    cs_word            = '0;
    cs_word[FIFO_AW:0] = used;
    cs_word[8]         = (state != IDLE);
    cs_word[9]         = full;
    cs_word[10]        = irq_pend;
    cs_word[11]        = ovf;
    cs_word[12]        = irq_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend   <= 1'b0;
      irq_en     <= 1'b0;
      ovf        <= 1'b0;
      s_readdata <= '0;
    end else begin
      if (irq_set)                        irq_pend <= 1'b1;
      else if (wr_cs && s_writedata[1])   irq_pend <= 1'b0;
      if (wr_cs)                          irq_en   <= s_writedata[2];
      if (drop)                           ovf      <= 1'b1;
      else if (wr_cs && s_writedata[3])   ovf      <= 1'b0;
      s_readdata <= (rd_en && s_address) ? cs_word : 32'd0;
    end
  end

endmodule

// File: tb/tb_ir_tx_nec_fifo.sv
// Scoreboard bench for ir_tx_nec_fifo: queued NEC words are checked against a waveform model,
// CS reads against hand-computed status words.
module tb_ir_tx_nec_fifo;

  localparam int U   = 4;
  localparam int CP  = 3;
  localparam int CH  = 1;
  localparam int GU  = 2;
  localparam int FAW = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq;
  logic        s_address = 1'b0;
  logic        s_cs_n = 1'b1;
  logic        s_read = 1'b0;
  logic [31:0] s_readdata;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic        ir;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames_done = 0;
  logic [31:0] fq[$];
  logic [31:0] rq[$];
  logic        rd_q = 1'b0;

  ir_tx_nec_fifo #(
    .UNIT_CYCLES(U), .CARRIER_PERIOD(CP), .CARRIER_HIGH(CH),
    .GAP_UNITS(GU), .FIFO_AW(FAW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .s_address(s_address),
    .s_cs_n(s_cs_n), .s_read(s_read), .s_readdata(s_readdata),
    .s_write(s_write), .s_writedata(s_writedata), .ir(ir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_q <= s_read & ~s_cs_n & reset_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic mark_val(input int j);
`ifdef IR_TX_CARRIER_EN
    return (j % CP) < CH;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic exp_ir(input logic [31:0] w, input int k);
    int pos;
    if (k < 16*U) return mark_val(k);
    pos = 24*U;
    if (k < pos) return 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (k < pos + U) return mark_val(k - pos);
      pos += U * (w[i] ? 4 : 2);
      if (k < pos) return 1'b0;
    end
    if (k < pos + U) return mark_val(k - pos);
    return 1'b0;
  endfunction

  function automatic int frame_len(input logic [31:0] w);
    int n;
    n = 24*U + U + GU*U;
    for (int i = 0; i < 32; i++) n += U * (w[i] ? 4 : 2);
    return n;
  endfunction

  // frame monitor: every ir rise starts a frame that must match the oldest queued word
  initial begin : frame_mon
    logic [31:0] w;
    int len, bad;
    bit aborted;
    forever begin
      @(negedge clk);
      if (reset_n && ir === 1'b1) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: ir=1 with no queued word (t=%0t)", $time);
          repeat (400) @(negedge clk);
        end else begin
          w = fq.pop_front();
          len = frame_len(w);
          bad = 0;
          aborted = 1'b0;
          for (int k = 0; k < len; k++) begin
            if (k > 0) @(negedge clk);
            if (!reset_n) begin
              aborted = 1'b1;
              break;
            end
            if (ir !== exp_ir(w, k)) bad++;
          end
          if (!aborted) begin
            checks++;
            if (bad != 0) begin
              errors++;
              $display("FAIL frame_%08h: %0d wrong ir cycles, required 0", w, bad);
            end
            frames_done++;
          end
        end
      end
    end
  end

  initial begin : read_mon
    forever begin
      @(negedge clk);
      if (rd_q) begin
        if (rq.size() == 0) chk("read_unexpected", s_readdata, 32'hxxxxxxxx);
        else                chk("cs_read", s_readdata, rq.pop_front());
      end
    end
  end

  task automatic bus_wr(input logic a, input logic [31:0] d);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = a; s_writedata = d;
    @(negedge clk);
    s_cs_n = 1'b1; s_write = 1'b0;
  endtask

  task automatic cs_rd(input logic [31:0] exp);
    rq.push_back(exp);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = 1'b1;
    @(negedge clk);
    s_cs_n = 1'b1; s_read = 1'b0;
  endtask

  task automatic send(input logic [31:0] w);
    fq.push_back(w);
    bus_wr(1'b0, w);
  endtask

  task automatic first_ir(output int t0);
    int n = 0;
    while (ir !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("first_ir_latency", n, 1);
    t0 = cyc;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int k = 0;
    while (frames_done < n && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("frames_done", frames_done, n);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] burst [9] = '{32'h00000000, 32'hFFFF0000, 32'h12345678, 32'h87654321,
                             32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000, 32'h00C0FFEE,
                             32'hBAD0BAD0};

  initial begin : stim
    int t0;
    repeat (3) @(negedge clk);
    chk("reset_ir", ir, 0);
    chk("reset_irq", irq, 0);
    chk("reset_readdata", s_readdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    cs_rd(32'h0);

    // single frame, baseline timing
    send(32'h00000001);
    first_ir(t0);
    wait_until(t0 + 371);
    cs_rd(32'h0000_0500);
    cs_rd(32'h0000_0400);
    chk("irq_masked", irq, 0);
    bus_wr(1'b1, 32'h2);

    // interrupt on drain
    bus_wr(1'b1, 32'h4);
    chk("irq_en_no_pend", irq, 0);
    send(32'hA5A5A5A5);
    first_ir(t0);
    wait_until(t0 + 483);
    chk("irq_before_stop_end", irq, 0);
    @(negedge clk);
    chk("irq_after_stop_end", irq, 1);
    bus_wr(1'b1, 32'h6);
    chk("irq_cleared", irq, 0);
    cs_rd(32'h0000_1100);
    wait_frames(2);

    // overflow: 8 of 9 words accepted while the FSM is busy
    send(32'hCAFEF00D);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) fq.push_back(burst[i]);
      bus_wr(1'b0, burst[i]);
    end
    cs_rd(32'h0000_1B08);
    bus_wr(1'b1, 32'hC);
    cs_rd(32'h0000_1308);
    wait_frames(11);
    chk("irq_after_burst", irq, 1);
    cs_rd(32'h0000_1400);
    bus_wr(1'b1, 32'h6);

    // FIFO clear during a frame
    send(32'h11111111);
    bus_wr(1'b0, 32'h22222222);
    bus_wr(1'b0, 32'h33333333);
    repeat (20) @(negedge clk);
    bus_wr(1'b1, 32'h5);
    cs_rd(32'h0000_1100);
    wait_frames(12);
    chk("irq_after_clear_frame", irq, 1);
    cs_rd(32'h0000_1400);
    repeat (40) @(negedge clk);
    bus_wr(1'b1, 32'h2);
    chk("irq_off", irq, 0);

    // reset in the middle of the leader mark
    send(32'h12345678);
    first_ir(t0);
    wait_until(t0 + 21);
    chk("ir_mid_lead", ir, 1);
    reset_n = 1'b0;
    #1;
    chk("ir_async_reset", ir, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cs_rd(32'h0);
    repeat (60) @(negedge clk);
    chk("frame_queue_empty", fq.size(), 0);
    chk("read_queue_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
